// File: rtl/control_unit_mc.sv
// Purpose : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the 16-bit datapath controls.
// Latency : RTYPE/ADDI 4 cycles, SW 4+W, LW 5+W (W = MEM cycles with mem_ready low).
// Backpressure: mem_ready low stalls in MEM; run low holds in FETCH at the instruction boundary.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   run               - sampled in FETCH only; low parks the sequencer between instructions
//   opcode            - datapath opcode, captured into op_q in DECODE
//   mem_ready         - data-memory completion, looked at only in MEM
//   pc_write/ir_write - fetch strobes
//   RegDst..ALUOp     - Moore datapath controls (combinational from state and op_q)
//   state_o           - current state code
//   instr_retired     - retired-instruction counter
//
// Optional feature: define CTRL_PERF_CNT_EN to build the retired-instruction counter;
// without it instr_retired is tied to zero and no counter flops exist.
module control_unit_mc #(
  parameter logic [1:0] OP_RTYPE = 2'b00,
  parameter logic [1:0] OP_LW    = 2'b01,
  parameter logic [1:0] OP_SW    = 2'b10,
  parameter logic [1:0] OP_ADDI  = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [1:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUOp,
  output logic [2:0]  state_o,
  output logic [15:0] instr_retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t     state_q;
  logic [1:0] op_q;

  // Opcode class decodes, all taken from the latched opcode so a changing
  // datapath opcode after DECODE cannot redirect the instruction in flight.
  logic is_rtype;
  logic is_lw;
  logic is_sw;
  logic is_alu_only;

  assign is_rtype    = (op_q == OP_RTYPE);
  assign is_lw       = (op_q == OP_LW);
  assign is_sw       = (op_q == OP_SW);
  assign is_alu_only = (op_q == OP_RTYPE) || (op_q == OP_ADDI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 2'b00;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (run) state_q <= S_DECODE;
        end
        S_DECODE: begin
          op_q    <= opcode;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= is_alu_only ? S_WB : S_MEM;
        end
        S_MEM: begin
          // Loads still need write-back; stores retire straight out of MEM.
          if (mem_ready) state_q <= is_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          state_q <= S_FETCH;
        end
        default: begin
          // Unused codes 5-7 recover to FETCH.
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  // Moore outputs. The reset term makes the strobes drop the moment reset
  // rises, without waiting for the state register to be cleared by an edge.
  always_comb begin
    pc_write = 1'b0;
    ir_write = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          pc_write = run;
          ir_write = run;
        end
        S_EXEC: begin
          ALUSrc = !is_rtype;
          ALUOp  = is_rtype;
          RegDst = is_rtype;
        end
        S_MEM: begin
          // Held steady through wait cycles so memory sees a stable request.
          ALUSrc   = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemToReg = is_lw;
          RegDst   = is_rtype;
          ALUSrc   = !is_rtype;
          ALUOp    = is_rtype;
        end
        default: begin
        end
      endcase
    end
  end

  assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
  // An instruction retires on the edge that leaves WB, or that leaves MEM
  // for a store (stores have no WB).
  logic        retire_evt;
  logic [15:0] retired_q;

  assign retire_evt = (state_q == S_WB) ||
                      ((state_q == S_MEM) && mem_ready && is_sw);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 16'h0000;
    end else if (retire_evt) begin
      retired_q <= retired_q + 16'h0001;
    end
  end

  assign instr_retired = retired_q;
`else
  assign instr_retired = 16'h0000;
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
// Purpose : scoreboard bench for control_unit_mc; expected per-cycle outputs are
//           derived from an instruction-level model and checked by a monitor.
module tb_control_unit_mc;

  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_LW    = 2'b01;
  localparam logic [1:0] OP_SW    = 2'b10;
  localparam logic [1:0] OP_ADDI  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  opcode;
  logic        mem_ready;
  logic        pc_write, ir_write, RegDst, ALUSrc, MemToReg;
  logic        RegWrite, MemRead, MemWrite, ALUOp;
  logic [2:0]  state_o;
  logic [15:0] instr_retired;

  control_unit_mc dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .RegDst        (RegDst),
    .ALUSrc        (ALUSrc),
    .MemToReg      (MemToReg),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .ALUOp         (ALUOp),
    .state_o       (state_o),
    .instr_retired (instr_retired)
  );

  always #5 clk = ~clk;

  // Control vector order: pc_write, ir_write, RegDst, ALUSrc, MemToReg,
  // RegWrite, MemRead, MemWrite, ALUOp.
  logic [8:0] ctl_act;
  assign ctl_act = {pc_write, ir_write, RegDst, ALUSrc, MemToReg,
                    RegWrite, MemRead, MemWrite, ALUOp};

  typedef struct packed {
    logic [2:0]  st;
    logic [8:0]  ctl;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   retired = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] cb(input bit pc, input bit ir, input bit rd, input bit as,
                                    input bit mtr, input bit rw, input bit mr,
                                    input bit mw, input bit ao);
    return {pc, ir, rd, as, mtr, rw, mr, mw, ao};
  endfunction

  function automatic exp_t mk(input logic [2:0] st, input logic [8:0] ctl);
    exp_t e;
    e.st  = st;
    e.ctl = ctl;
`ifdef CTRL_PERF_CNT_EN
    e.ret = retired[15:0];
`else
    e.ret = 16'h0000;
`endif
    return e;
  endfunction

  function automatic logic [1:0] noise(input bit fixed, input logic [1:0] nv);
    return fixed ? nv : 2'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Monitor: one expected record per clock while enabled.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got no expectation for state %0d at %0t", state_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("state", {29'd0, state_o}, {29'd0, e.st});
        check("ctl", {23'd0, ctl_act}, {23'd0, e.ctl});
        check("retired", {16'd0, instr_retired}, {16'd0, e.ret});
      end
    end
  end

  // Called at posedge+1: drive this cycle's inputs, record what the outputs must be.
  task automatic drive(input logic r, input logic [1:0] op, input logic mr, input exp_t e);
    run       = r;
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 2'($urandom), rbit(), mk(3'd0, 9'd0));
  endtask

  // One instruction as the sequence of cycles it must produce. Opcode is only
  // meaningful in the DECODE cycle; elsewhere it is noise (or a fixed value).
  task automatic do_instr(input logic [1:0] op, input int w, input bit fixed, input logic [1:0] nv);
    bit rt = (op == OP_RTYPE);
    bit lw = (op == OP_LW);
    bit sw = (op == OP_SW);
    drive(1'b1, noise(fixed, nv), rbit(), mk(3'd0, cb(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    drive(rbit(), op, rbit(), mk(3'd1, 9'd0));
    drive(rbit(), noise(fixed, nv), rbit(), mk(3'd2, cb(0, 0, rt, !rt, 0, 0, 0, 0, rt)));
    if (lw || sw) begin
      for (int i = 0; i <= w; i++) begin
        drive(rbit(), noise(fixed, nv), (i == w), mk(3'd3, cb(0, 0, 0, 1, 0, 0, lw, sw, 0)));
      end
    end
    if (!sw) begin
      drive(rbit(), noise(fixed, nv), rbit(), mk(3'd4, cb(0, 0, rt, !rt, lw, 1, 0, 0, rt)));
    end
    retired++;
  endtask

  task automatic random_block(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      do_instr(2'($urandom), int'($urandom_range(0, 3)), 1'b0, 2'b00);
    end
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b1;
    opcode    = 2'b00;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Outputs forced low during reset even with run high.
    check("rst_state", {29'd0, state_o}, 32'd0);
    check("rst_ctl", {23'd0, ctl_act}, 32'd0);
    check("rst_retired", {16'd0, instr_retired}, 32'd0);

    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed sequences from the plan.
    do_instr(OP_RTYPE, 0, 1'b0, 2'b00);
    do_instr(OP_RTYPE, 0, 1'b0, 2'b00);
    do_instr(OP_LW, 3, 1'b0, 2'b00);
    do_instr(OP_SW, 0, 1'b0, 2'b00);
    do_instr(OP_ADDI, 0, 1'b1, 2'b10);
    idle_cycle();
    idle_cycle();

    random_block(300);

    // Reset in the middle of a stalled store.
    mon_en = 1'b0;
    check("sb_drain", exp_q.size(), 32'd0);
    run       = 1'b1;
    opcode    = OP_SW;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run = 1'b0;
    check("mid_mem_state", {29'd0, state_o}, 32'd3);
    check("mid_mem_memwrite", {31'd0, MemWrite}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_async_state", {29'd0, state_o}, 32'd0);
    check("rst_async_ctl", {23'd0, ctl_act}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_state", {29'd0, state_o}, 32'd0);
    check("post_rst_retired", {16'd0, instr_retired}, 32'd0);
    retired = 0;

    mon_en = 1'b1;
    random_block(60);
    mon_en = 1'b0;
    check("sb_final_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multi-cycle control unit driving the 16-bit datapath's control inputs from its 2-bit `opcode` output. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. It latches the opcode at decode and produces Moore-style control strobes. It also handshakes with data memory through `mem_ready` so that loads and stores can take wait states.

## Interface
Parameters:
- `OP_RTYPE`, default 2'b00: R-format opcode; ALU function comes from `funct`.
- `OP_LW`, default 2'b01: load word.
- `OP_SW`, default 2'b10: store word.
- `OP_ADDI`, default 2'b11: add sign-extended immediate.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `run`  in  1: when low, the FSM holds in FETCH at the instruction boundary.
- `opcode`  in  2: instruction opcode from the datapath.
- `mem_ready`  in  1: data memory completion for the current MEM access.
- `pc_write`  out  1: PC increment strobe.
- `ir_write`  out  1: instruction register load strobe.
- `RegDst`, `ALUSrc`, `MemToReg`, `RegWrite`, `MemRead`, `MemWrite`, `ALUOp`  out  1 each: datapath controls.
- `state_o`  out  3: current state encoding.
- `instr_retired`  out  16: retired-instruction count (see Configuration).

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 drive all outputs to 0 and go to FETCH on the next edge.
- `op_q` is a 2-bit opcode register, loaded from `opcode` in DECODE. All per-opcode decisions in EXEC, MEM and WB use `op_q`, not the live `opcode`.
- FETCH: `ir_write` and `pc_write` equal `run`. If `run`=1 go to DECODE, else stay in FETCH.
- DECODE: capture `op_q`, no strobes, go to EXEC.
- EXEC:
  - `ALUSrc`=(op_q≠OP_RTYPE), `ALUOp`=(op_q==OP_RTYPE), `RegDst`=(op_q==OP_RTYPE).
  - RTYPE and ADDI go to WB; LW and SW go to MEM.
- MEM:
  - `ALUSrc`=1 held; `MemRead`=(op_q==OP_LW); `MemWrite`=(op_q==OP_SW).
  - Stay in MEM while `mem_ready`=0.
  - On `mem_ready`=1: LW goes to WB, SW goes to FETCH.
- WB:
  - `RegWrite`=1, `MemToReg`=(op_q==OP_LW), `RegDst`=(op_q==OP_RTYPE).
  - `ALUSrc` and `ALUOp` held at their EXEC values.
  - Go to FETCH.
- Any control not listed for a state is 0.
- `mem_ready` is ignored outside MEM.
- `run` is sampled only in FETCH. Deasserting it mid-instruction lets that instruction complete.

## Timing
- Outputs are combinational functions of state and `op_q`, gated to 0 while `reset`=1. No output is registered.
- Reset:
  - `reset` high immediately forces state=FETCH, `op_q`=0 and `instr_retired`=0.
  - All outputs are 0 while reset is high, including `pc_write`.
  - A reset during MEM drops `MemWrite`/`MemRead` without waiting for a clock edge.
- Latency, from the FETCH edge to the next FETCH, with W = MEM cycles where `mem_ready`=0:
  - RTYPE and ADDI: 4 cycles.
  - SW: 4+W cycles.
  - LW: 5+W cycles.
- `MemWrite` and `MemRead` stay asserted and constant for every MEM cycle, including wait cycles.
- `RegWrite` asserts for exactly one cycle per RTYPE, ADDI or LW instruction, and never for SW.
- `pc_write` asserts for exactly one cycle per fetched instruction.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - `instr_retired` increments by 1 on the edge leaving WB, or leaving MEM for SW.
  - Wraps from 16'hFFFF to 16'h0000; cleared by `reset`.
- Undefined: `instr_retired` is tied to 16'h0000 and no counter flops exist.

## Test plan
- Reset, then `run`=1 with `opcode`=00 → states 0,1,2,4,0. `RegDst`=1 in EXEC and WB, `RegWrite`=1 only in WB, `pc_write` high one cycle per 4.
- LW with `mem_ready` low for 3 MEM cycles then high → `MemRead`=1 for 4 consecutive cycles. Then WB with `MemToReg`=1 and `RegWrite`=1. Total 8 cycles.
- SW with `mem_ready`=1 on the first MEM cycle → `MemWrite`=1 for one cycle, `RegWrite` never asserted, FETCH after 4 cycles.
- ADDI with `opcode` changed to 2'b10 during EXEC → WB still taken, `ALUSrc`=1, no MEM state.
- Assert `reset` mid-MEM of an SW → `MemWrite` falls before the next edge. After release, state=0 and the counter=0.
- With `CTRL_PERF_CNT_EN` and the counter preset near wrap by running 65537 RTYPE instructions → `instr_retired`=16'h0001. Without the macro it stays 0.
